// File: rtl/r88_pkg.sv
// Shared definitions for the r88 external memory controller.
//   - controller state encoding
//   - read value returned on a bus timeout (all-ones, sliced to DATA_W)
//   - default parameter values
package r88_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_WAITRDY,
    ST_DONE
  } r88_state_t;

  localparam int unsigned R88_DATA_W_DEF      = 8;
  localparam int unsigned R88_ADDR_W_DEF      = 16;
  localparam int unsigned R88_WAIT_STATES_DEF = 0;
  localparam int unsigned R88_TIMEOUT_DEF     = 255;
  localparam int unsigned R88_AUTO_INC_DEF    = 1;

  // Widest supported timeout read value; users slice it to their DATA_W.
  localparam logic [63:0] R88_TO_RDATA_MAX = '1;
  localparam logic [R88_DATA_W_DEF-1:0] R88_TO_RDATA = R88_TO_RDATA_MAX[R88_DATA_W_DEF-1:0];

endpackage

// File: rtl/r88_mem_ctrl_ws_wait_counter.sv
// Loadable down-counter with a zero flag. Used for the fixed wait-state
// count and for the memReady timeout count.
//   i_clk      clock
//   i_rst      synchronous active-high reset (count -> 0)
//   i_load     load i_load_val (has priority over i_dec)
//   i_load_val value to load
//   i_dec      decrement; saturates at zero
//   o_count    current count
//   o_zero     count == 0
module r88_wait_counter #(
  parameter int unsigned W = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic [W-1:0] o_count,
  output logic         o_zero
);

  logic [W-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_count = r_count;
  assign o_zero  = (r_count == '0);

endmodule

// File: rtl/r88_mem_ctrl_ws.sv
// External memory controller with programmable wait states, memReady
// handshake, bus timeout and optional address auto-increment.
//   sysClock/resetReq      clock, synchronous active-high reset
//   intDIn / intDOut       internal data bus in (address bytes, write data) / read data out
//   mc_write_low/high      load latchAddr low / high part from intDIn
//   mc_use_regAddr,regAddr use the register-block address instead of latchAddr
//   reqRead / reqWrite     start an access (read wins if both)
//   busy, done, timeoutErr access status (done/timeoutErr are 1-cycle pulses)
//   extA, extDOut, extDOutEn, extDIn, readMem, writeMem, memReady  external bus
module r88_mem_ctrl_ws
  import r88_pkg::*;
#(
  parameter int unsigned DATA_W      = R88_DATA_W_DEF,
  parameter int unsigned ADDR_W      = R88_ADDR_W_DEF,
  parameter int unsigned WAIT_STATES = R88_WAIT_STATES_DEF,
  parameter int unsigned TIMEOUT     = R88_TIMEOUT_DEF,
  parameter int unsigned AUTO_INC    = R88_AUTO_INC_DEF
) (
  input  logic              sysClock,
  input  logic              resetReq,
  input  logic [DATA_W-1:0] intDIn,
  output logic [DATA_W-1:0] intDOut,
  input  logic              mc_write_low,
  input  logic              mc_write_high,
  input  logic              mc_use_regAddr,
  input  logic [ADDR_W-1:0] regAddr,
  input  logic              reqRead,
  input  logic              reqWrite,
  output logic              busy,
  output logic              done,
  output logic              timeoutErr,
  output logic [ADDR_W-1:0] extA,
  output logic [DATA_W-1:0] extDOut,
  output logic              extDOutEn,
  input  logic [DATA_W-1:0] extDIn,
  output logic              readMem,
  output logic              writeMem,
  input  logic              memReady
);

  localparam int unsigned WS_W = 4;
  localparam int unsigned TO_W = 8;
  localparam logic [DATA_W-1:0] TO_RDATA = R88_TO_RDATA_MAX[DATA_W-1:0];

  r88_state_t r_state, w_next;

  logic [ADDR_W-1:0] r_latch;
  logic [ADDR_W-1:0] r_extA;
  logic [DATA_W-1:0] r_extDOut;
  logic [DATA_W-1:0] r_intDOut;
  logic              r_isRead;
  logic              r_useLatch;
  logic              r_timeout;

  logic              w_accept;
  logic              w_waitDec;
  logic              w_toLoad;
  logic              w_toDec;
  logic              w_finish;
  logic              w_timeout;
  logic              w_autoInc;
  logic              w_strobe;
  logic              w_waitZero;
  logic              w_toZero;
  logic [WS_W-1:0]   w_waitCnt;
  logic [TO_W-1:0]   w_toCnt;
  logic              w_unused_waitcnt;

  r88_wait_counter #(.W(WS_W)) u_wait_cnt (
    .i_clk      (sysClock),
    .i_rst      (resetReq),
    .i_load     (w_accept),
    .i_load_val (WS_W'(WAIT_STATES)),
    .i_dec      (w_waitDec),
    .o_count    (w_waitCnt),
    .o_zero     (w_waitZero)
  );

  r88_wait_counter #(.W(TO_W)) u_to_cnt (
    .i_clk      (sysClock),
    .i_rst      (resetReq),
    .i_load     (w_toLoad),
    .i_load_val (TO_W'(TIMEOUT)),
    .i_dec      (w_toDec),
    .o_count    (w_toCnt),
    .o_zero     (w_toZero)
  );

  assign w_unused_waitcnt = ^w_waitCnt;

  always_ff @(posedge sysClock) begin
    if (resetReq) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    w_waitDec = 1'b0;
    w_toLoad  = 1'b0;
    w_toDec   = 1'b0;
    w_finish  = 1'b0;
    w_timeout = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (reqRead || reqWrite) begin
          w_accept = 1'b1;
          w_next   = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (!w_waitZero) begin
          w_waitDec = 1'b1;
        end else if (memReady) begin
          w_finish = 1'b1;
          w_next   = ST_DONE;
        end else begin
          w_toLoad = 1'b1;
          w_next   = ST_WAITRDY;
        end
      end
      ST_WAITRDY: begin
        if (memReady) begin
          w_finish = 1'b1;
          w_next   = ST_DONE;
        end else if ((w_toCnt == TO_W'(1)) || w_toZero) begin
          // zero only reachable with an out-of-range TIMEOUT; treat as expired
          w_finish  = 1'b1;
          w_timeout = 1'b1;
          w_next    = ST_DONE;
        end else begin
          w_toDec = 1'b1;
        end
      end
      ST_DONE: begin
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  assign w_autoInc = (AUTO_INC != 0) && (r_state == ST_DONE) && r_useLatch;

  always_ff @(posedge sysClock) begin
    if (resetReq) begin
      r_latch    <= '0;
      r_extA     <= '0;
      r_extDOut  <= '0;
      r_intDOut  <= '0;
      r_isRead   <= 1'b0;
      r_useLatch <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_isRead   <= reqRead;
        r_useLatch <= ~mc_use_regAddr;
        r_extA     <= mc_use_regAddr ? regAddr : r_latch;
        if (!reqRead) begin
          r_extDOut <= intDIn;
        end
      end
      if (w_finish) begin
        r_timeout <= w_timeout;
        if (r_isRead) begin
          r_intDOut <= w_timeout ? TO_RDATA : extDIn;
        end
      end
      // A latch write in the DONE cycle suppresses the auto-increment entirely.
      if (mc_write_low || mc_write_high) begin
        if (mc_write_low) begin
          r_latch[DATA_W-1:0] <= intDIn;
        end
        if (mc_write_high) begin
          r_latch[ADDR_W-1:DATA_W] <= intDIn[ADDR_W-DATA_W-1:0];
        end
      end else if (w_autoInc) begin
        r_latch <= r_latch + ADDR_W'(1);
      end
    end
  end

  assign w_strobe   = (r_state == ST_ACCESS) || (r_state == ST_WAITRDY);
  assign busy       = (r_state != ST_IDLE);
  assign done       = (r_state == ST_DONE);
  assign timeoutErr = (r_state == ST_DONE) && r_timeout;
  assign readMem    = w_strobe && r_isRead;
  assign writeMem   = w_strobe && !r_isRead;
  assign extDOutEn  = w_strobe && !r_isRead;
  assign extA       = r_extA;
  assign extDOut    = r_extDOut;
  assign intDOut    = r_intDOut;

endmodule
